// File: rtl/imem_loader.sv
// Boot-time loader: parses a little-endian word count from a byte stream, packs 32-bit
// little-endian instructions into the instruction memory, and holds the core in reset until done.
module imem_loader #(
  parameter int DATA      = 32,
  parameter int ADDR      = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_byte,
  output logic            in_ready,
  input  logic            reload,
  output logic            mem_we,
  output logic [DATA-1:0] mem_wd,
  output logic [ADDR-1:0] mem_addr,
  output logic            core_rst,
  output logic            load_done,
  output logic            load_err,
  output logic [15:0]     words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t          state;
  logic [15:0]     count;
  logic [1:0]      byte_idx;
  logic [DATA-1:0] word_p0;
  logic            take;
  logic [15:0]     len_full;

  assign take     = in_valid && in_ready;
  assign len_full = {in_byte, count[7:0]};

  // Handshake and status outputs decode only the state register, never in_valid.
  assign in_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign mem_we    = (state == S_WRITE);
  assign core_rst  = (state != S_DONE);
  assign load_done = (state == S_DONE);
  assign load_err  = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      byte_idx     <= '0;
      mem_wd       <= '0;
      mem_addr     <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_LEN_LO;
        S_LEN_LO: begin
          if (take) begin
            count[7:0] <= in_byte;
            state      <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (take) begin
            count[15:8]  <= in_byte;
            byte_idx     <= '0;
            words_loaded <= '0;
            if (len_full == 16'd0)
              state <= S_DONE;
            else if (len_full > 16'(MEM_DEPTH))
              state <= S_ERR;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (take) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_wd   <= {in_byte, word_p0[DATA-1:8]};
              mem_addr <= ADDR'({words_loaded, 2'b00});
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          state        <= (words_loaded + 16'd1 == count) ? S_DONE : S_DATA;
        end
        S_DONE, S_ERR: begin
          if (reload) begin
            words_loaded <= '0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bytes shift in from the top so the first byte ends up in bits [7:0] after four accepts;
  // byte_idx restarting at 0 guarantees no partial word survives a reset.
  always_ff @(posedge clk) begin
    if (state == S_DATA && take)
      word_p0 <= {in_byte, word_p0[DATA-1:8]};
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte streams (directed and random) are checked against a queue of
// expected memory writes and final load status derived from the stream contents.
module tb_imem_loader;
  localparam int DATA      = 32;
  localparam int ADDR      = 32;
  localparam int MEM_DEPTH = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [7:0]      in_byte;
  logic            in_ready;
  logic            reload;
  logic            mem_we;
  logic [DATA-1:0] mem_wd;
  logic [ADDR-1:0] mem_addr;
  logic            core_rst;
  logic            load_done;
  logic            load_err;
  logic [15:0]     words_loaded;

  imem_loader #(.DATA(DATA), .ADDR(ADDR), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .reload(reload), .mem_we(mem_we), .mem_wd(mem_wd), .mem_addr(mem_addr),
    .core_rst(core_rst), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  wr_t        exp_q[$];
  wr_t        got_q[$];
  logic [7:0] stream[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every write pulse must match the next expected write; the cycle after the final one
  // must show the program released.
  initial begin
    bit  after_last;
    wr_t e;
    after_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        after_last = 1'b0;
      end else begin
        if (after_last) begin
          check("done_after_last_write", load_done, 1);
          check("core_rst_after_last_write", core_rst, 0);
          after_last = 1'b0;
        end
        check("core_rst_vs_done", core_rst, !load_done);
        if (mem_we) begin
          got_q.push_back({mem_addr, mem_wd});
          check("in_ready_low_in_write", in_ready, 0);
          check("core_rst_high_in_write", core_rst, 1);
          check("write_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("write_addr", mem_addr, e.addr);
            check("write_data", mem_wd, e.data);
            if (exp_q.size() == 0) after_last = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit noise);
    int guard;
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      reload   = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_byte  = b;
    reload   = noise ? 1'($urandom) : 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      reload = noise ? 1'($urandom) : 1'b0;
      guard++;
    end
    check("byte_handshake", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    reload   = 1'b0;
  endtask

  task automatic build_stream(input int cnt);
    logic [31:0] w;
    stream.delete();
    stream.push_back(8'(cnt));
    stream.push_back(8'(cnt >> 8));
    if (cnt <= MEM_DEPTH) begin
      for (int i = 0; i < cnt; i++) begin
        w = $urandom;
        stream.push_back(w[7:0]);
        stream.push_back(w[15:8]);
        stream.push_back(w[23:16]);
        stream.push_back(w[31:24]);
      end
    end
  endtask

  // Expected writes follow directly from the stream: word i sits at byte address 4*i.
  task automatic plan(output bit exp_err, output int exp_words);
    int cnt;
    cnt = int'({stream[1], stream[0]});
    exp_q.delete();
    exp_err   = 1'b0;
    exp_words = 0;
    if (cnt > MEM_DEPTH) begin
      exp_err = 1'b1;
    end else begin
      exp_words = cnt;
      for (int i = 0; i < cnt; i++)
        exp_q.push_back({32'(i * 4), stream[2+4*i+3], stream[2+4*i+2],
                         stream[2+4*i+1], stream[2+4*i]});
    end
  endtask

  task automatic run_load(input int gap_pct, input bit noise);
    bit err;
    int words;
    int guard;
    plan(err, words);
    got_q.delete();
    foreach (stream[i]) send_byte(stream[i], gap_pct, noise);
    if (err || words == 0) begin
      check("flag_err_immediate", load_err, err);
      check("flag_done_immediate", load_done, !err);
    end else begin
      guard = 0;
      while (!(load_done || load_err) && guard < 20) begin
        @(negedge clk);
        guard++;
      end
    end
    check("final_done", load_done, !err);
    check("final_err", load_err, err);
    check("final_core_rst", core_rst, err);
    check("final_words_loaded", words_loaded, words);
    check("pending_writes", exp_q.size(), 0);
    check("write_count", got_q.size(), words);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_core_rst", core_rst, 1);
    check("reload_done", load_done, 0);
    check("reload_err", load_err, 0);
    check("reload_words", words_loaded, 0);
    check("reload_in_ready", in_ready, 0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wd", mem_wd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_words_loaded", words_loaded, 0);
  endtask

  initial begin
    int cnt;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    reload   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);
    check("first_byte_ready_after_idle", in_ready, 1);

    // Normal two-word load
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(0, 1'b0);
    check("normal_words_lit", words_loaded, 16'd2);
    check("normal_core_rst_lit", core_rst, 0);
    if (got_q.size() >= 2) begin
      check("normal_w0_addr", got_q[0].addr, 32'h0);
      check("normal_w0_data", got_q[0].data, 32'h00000013);
      check("normal_w1_addr", got_q[1].addr, 32'h4);
      check("normal_w1_data", got_q[1].data, 32'h00100093);
    end

    // Same stream with gaps and reload noise
    do_reload();
    run_load(50, 1'b1);

    // Zero count
    do_reload();
    stream = '{8'h00, 8'h00};
    run_load(0, 1'b0);
    check("zero_words_lit", words_loaded, 16'd0);
    check("zero_core_rst_lit", core_rst, 0);

    // Oversize count 257, sticky error, then recovery
    do_reload();
    stream = '{8'h01, 8'h01};
    run_load(0, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky", load_err, 1);
    check("err_core_rst_lit", core_rst, 1);
    do_reload();
    build_stream(1);
    run_load(0, 1'b0);

    // Reload after DONE, known word
    do_reload();
    stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(0, 1'b0);
    if (got_q.size() >= 1) begin
      check("deadbeef_addr", got_q[0].addr, 32'h0);
      check("deadbeef_data", got_q[0].data, 32'hDEADBEEF);
    end

    // Reset after two of four data bytes, then a fresh load
    do_reload();
    exp_q.delete();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    stream = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    run_load(0, 1'b0);
    if (got_q.size() >= 1) begin
      check("after_rst_addr", got_q[0].addr, 32'h0);
      check("after_rst_data", got_q[0].data, 32'h11223344);
    end

    // Boundaries: exactly MEM_DEPTH words, then MEM_DEPTH+1
    do_reload();
    build_stream(MEM_DEPTH);
    run_load(0, 1'b0);
    do_reload();
    build_stream(MEM_DEPTH + 1);
    run_load(0, 1'b0);

    // Random loads
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(9))
        0:       cnt = 0;
        1:       cnt = $urandom_range(65535, MEM_DEPTH + 1);
        default: cnt = $urandom_range(8, 1);
      endcase
      do_reload();
      build_stream(cnt);
      run_load($urandom_range(2) * 30, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
